// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Latency: none (constants and types only).
// Backpressure: not applicable.
// Contents: funct3 access-size codes, FSM state type, request fault decode helpers.
package lsu_bus_ctrl_pkg;

  // funct3 codes for loads/stores
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Invalid funct3 for the requested direction, or both directions at once.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3);
    logic bad_load;
    logic bad_store;
    bad_load  = (f3 != MEM_B) && (f3 != MEM_H) && (f3 != MEM_W) &&
                (f3 != MEM_BU) && (f3 != MEM_HU);
    // Stores have no unsigned variants: only b/h/w are meaningful.
    bad_store = (f3 != MEM_B) && (f3 != MEM_H) && (f3 != MEM_W);
    return (rd & wr) | (rd & bad_load) | (wr & bad_store);
  endfunction

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic req_misaligned(input logic [2:0] f3,
                                          input logic [1:0] offs);
    logic is_half;
    logic is_word;
    is_half = (f3 == MEM_H) || (f3 == MEM_HU);
    is_word = (f3 == MEM_W);
    return (is_half & offs[0]) | (is_word & (offs != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extraction with extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the results are used.
// Ports: funct3/offs select size and lane; is_store picks store enables; store_data -> be/wdata; rdata -> ext.
module lsu_lane_align
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offs,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ext
);

  logic [31:0] lane;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << offs;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = offs[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Shift the addressed byte down to lane 0, then extend from there.
  always_comb begin
    lane = rdata >> {offs, 3'b000};
    ext  = lane;
    case (funct3)
      MEM_B:   ext = {{24{lane[7]}}, lane[7:0]};
      MEM_BU:  ext = {24'h000000, lane[7:0]};
      MEM_H:   ext = {{16{lane[15]}}, lane[15:0]};
      MEM_HU:  ext = {16'h0000, lane[15:0]};
      MEM_W:   ext = lane;
      default: ext = lane;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Memory-stage load/store unit: one decoded load/store -> one word-aligned bus transaction.
// Latency: request in cycle N, bus_req from N+1, bus_ready at N+1+k -> done at N+2+k.
// Backpressure: stall holds the pipeline from the request cycle until the bus answers or times out.
// Ports: clk/rst; mem_read/mem_write/funct3/addr/store_data from EX/MEM; stall/load_data/done and
//        misalign/illegal/bus_err pulses to the pipeline; bus_req/we/addr/be/wdata, bus_ready/rdata to memory.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misalign,
  output logic        illegal,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  // Counter value seen in the last BUSY cycle allowed before giving up.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic [31:0] ldata_q;

  logic        req;
  logic        req_ill;
  logic        req_mis;
  logic        accept;
  logic        busy;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_offs;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_c;

  assign req     = mem_read | mem_write;
  assign req_ill = req_illegal(mem_read, mem_write, funct3);
  assign req_mis = req_misaligned(funct3, addr[1:0]);
  assign busy    = (state_q == S_BUSY);

  // One aligner serves both phases: store steering from the live request
  // in IDLE, load extension from the latched request in BUSY.
  assign sel_f3   = busy ? f3_q : funct3;
  assign sel_offs = busy ? addr_q[1:0] : addr[1:0];

  lsu_lane_align u_align (
    .funct3     (sel_f3),
    .offs       (sel_offs),
    .is_store   (mem_write),
    .store_data (store_data),
    .rdata      (bus_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .ext        (ext_c)
  );

  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;
    load_data = 32'h0;
    // Outputs stay quiet for as long as reset is held, even with a request present.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (req_ill) begin
              illegal = 1'b1;
            end else if (req_mis) begin
              misalign = 1'b1;
            end else begin
              accept  = 1'b1;
              stall   = 1'b1;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          bus_req = 1'b1;
          stall   = 1'b1;
          if (bus_ready || (cnt_q == TO_LAST)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // Request inputs still belong to the finished instruction here.
          done      = 1'b1;
          bus_err   = err_q;
          load_data = ldata_q;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      cnt_q   <= 16'h0;
      err_q   <= 1'b0;
      ldata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= mem_write;
        addr_q  <= addr;
        be_q    <= be_c;
        wdata_q <= wdata_c;
        f3_q    <= funct3;
        cnt_q   <= 16'h0;
        err_q   <= 1'b0;
        ldata_q <= 32'h0;
      end else if (busy) begin
        cnt_q <= cnt_q + 16'h1;
        if (bus_ready) begin
          // Stores complete with zero load data.
          ldata_q <= we_q ? 32'h0 : ext_c;
        end else if (cnt_q == TO_LAST) begin
          err_q   <= 1'b1;
          ldata_q <= 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: vector table, randomized traffic against a reference model,
// and hand-written reset-in-flight sequence.
module tb_lsu_bus_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, misalign, illegal, bus_err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  // kind: 0 ok, 1 misalign, 2 illegal, 3 timeout
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rw;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    int          kind;
  } vec_t;

  vec_t vecs[14];

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .misalign   (misalign),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rw,
                              input int dly, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ld, input int kind);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.rw = rw;
    v.dly = dly; v.be = be; v.wd = wd; v.ld = ld; v.kind = kind;
    return v;
  endfunction

  // Reference model written from the access rules: size in bytes, shifts and masks.
  function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rw, input int dly);
    vec_t v;
    int nbytes, off;
    logic ill, mis;
    longint mask, val;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off    = int'(a % 4);
    ill    = (rd && wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3 >= 3'd3);
    mis    = !ill && ((int'(a % 32'(nbytes))) != 0);
    v = mk(rd, wr, f3, a, sd, rw, dly, 4'hF, 32'h0, 32'h0, 0);
    if (ill) v.kind = 2;
    else if (mis) v.kind = 1;
    else if (dly < 0 || dly >= T) v.kind = 3;
    if (wr) begin
      v.be = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1) v.wd = 32'(sd[7:0] * 32'h01010101);
      else if (nbytes == 2) v.wd = 32'(sd[15:0] * 32'h00010001);
      else v.wd = sd;
    end
    mask = (64'd1 << (8 * nbytes)) - 1;
    val  = (longint'(rw) >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 4 && ((val >> (8 * nbytes - 1)) & 1) == 1)
      val = val | (~mask & 64'hFFFFFFFF);
    v.ld = (wr || v.kind == 3) ? 32'h0 : val[31:0];
    return v;
  endfunction

  task automatic idle_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int nb;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.a; store_data = v.sd;
    @(negedge clk);
    if (v.kind == 1 || v.kind == 2) begin
      chk("misalign", 32'(misalign), 32'(v.kind == 1));
      chk("illegal", 32'(illegal), 32'(v.kind == 2));
      chk("fault_stall", 32'(stall), 32'd0);
      chk("fault_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      idle_in();
      @(negedge clk);
      chk("fault_no_busy", 32'(bus_req), 32'd0);
      chk("fault_no_done", 32'(done), 32'd0);
      return;
    end
    chk("req_stall", 32'(stall), 32'd1);
    chk("req_busreq", 32'(bus_req), 32'd0);
    nb = (v.dly >= 0 && v.dly < T) ? v.dly + 1 : T;
    for (int c = 0; c < nb; c++) begin
      @(posedge clk); #1;
      if (c == v.dly) begin
        bus_ready = 1'b1;
        bus_rdata = v.rw;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
      chk("busy_req", 32'(bus_req), 32'd1);
      chk("busy_stall", 32'(stall), 32'd1);
      chk("busy_done", 32'(done), 32'd0);
      chk("busy_addr", bus_addr, {v.a[31:2], 2'b00});
      chk("busy_be", 32'(bus_be), 32'(v.be));
      chk("busy_we", 32'(bus_we), 32'(v.wr));
      if (v.wr) chk("busy_wdata", bus_wdata, v.wd);
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req", 32'(bus_req), 32'd0);
    chk("load_data", load_data, v.ld);
    chk("bus_err", 32'(bus_err), 32'(v.kind == 3));
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    chk("after_done", 32'(done), 32'd0);
    chk("after_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [2:0] legal_f3[5];
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int op, dly;

    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

    vecs[0]  = mk(0, 1, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0, 4'b1000, 32'hABABABAB, 32'h0, 0);
    vecs[1]  = mk(1, 0, 3'b000, 32'h2001, 32'h0, 32'h123480FF, 1, 4'hF, 32'h0, 32'hFFFFFF80, 0);
    vecs[2]  = mk(1, 0, 3'b100, 32'h2001, 32'h0, 32'h123480FF, 0, 4'hF, 32'h0, 32'h00000080, 0);
    vecs[3]  = mk(1, 0, 3'b001, 32'h2002, 32'h0, 32'h80015555, 2, 4'hF, 32'h0, 32'hFFFF8001, 0);
    vecs[4]  = mk(1, 0, 3'b010, 32'h2002, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 1);
    vecs[5]  = mk(1, 0, 3'b001, 32'h2001, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 1);
    vecs[6]  = mk(1, 0, 3'b011, 32'h2000, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 2);
    vecs[7]  = mk(1, 0, 3'b010, 32'h3000, 32'h0, 32'hDEADBEEF, 3, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    vecs[8]  = mk(1, 0, 3'b010, 32'h3004, 32'h0, 32'h0, -1, 4'hF, 32'h0, 32'h0, 3);
    vecs[9]  = mk(0, 1, 3'b001, 32'h100E, 32'h1234ABCD, 32'h0, 1, 4'b1100, 32'hABCDABCD, 32'h0, 0);
    vecs[10] = mk(0, 1, 3'b010, 32'h1004, 32'hCAFEF00D, 32'h0, 2, 4'hF, 32'hCAFEF00D, 32'h0, 0);
    vecs[11] = mk(1, 1, 3'b010, 32'h1000, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 2);
    vecs[12] = mk(0, 1, 3'b100, 32'h1000, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 2);
    vecs[13] = mk(1, 0, 3'b101, 32'h2002, 32'h0, 32'h80015555, 0, 4'hF, 32'h0, 32'h00008001, 0);

    rst = 1'b1;
    idle_in();
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    bus_ready = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_err", 32'(bus_err | misalign | illegal), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 5));
      rd = (op <= 2) || (op == 5);
      wr = (op >= 3);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      dly = int'($urandom_range(0, 5));
      v = model(rd, wr, f3, a, $urandom, $urandom, dly);
      run_txn(v);
    end

    // Reset arriving in the second BUSY cycle abandons the access.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("inflight_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    idle_in();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_req", 32'(bus_req), 32'd0);
    end
    run_txn(mk(1, 0, 3'b000, 32'h2001, 32'h0, 32'h123480FF, 1, 4'hF, 32'h0, 32'hFFFFFF80, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
